stopwatch_ctrl: RTL and testbench

- Control sequencer for the stopwatch counter and 7-segment display path.
- Conditions four raw pushbuttons (start, stop, lap, clear): 2-flop sync, debounce, rising-edge detect.
- Runs a run/pause/lap state machine and generates the prescaled 1 Hz count-enable tick.
- Drives the counter's enable and clear, and the display freeze. Saturates at 59:59.

---
 rtl/stopwatch_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control sequencer for the stopwatch counter and its 7-segment display.
// The four raw buttons are synchronised, debounced and turned into one-cycle
// press events. The events drive a run/pause/lap state machine that also owns
// the 1 Hz prescaler.
//
// Ports
//   clk          system clock (single domain)
//   rst_n        synchronous active-low reset
//   start_btn    raw start button, asynchronous, active-high
//   stop_btn     raw stop button, asynchronous, active-high
//   lap_btn      raw lap button, asynchronous, active-high
//   clr_btn      raw clear button, asynchronous, active-high
//   cnt_max      counter currently reads 59:59
//   cnt_en       one-cycle count-increment pulse
//   cnt_clr      one-cycle counter clear pulse
//   disp_freeze  display holds its last value while high
//   running      high in RUN or LAP
//   state        IDLE=00, RUN=01, PAUSE=10, LAP=11
//   ovf          sticky saturation flag
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 10000000,
    parameter int DEB_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       lap_btn,
    input  logic       clr_btn,
    input  logic       cnt_max,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic       running,
    output logic [1:0] state,
    output logic       ovf
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    // Button bit order: 0=start, 1=stop, 2=lap, 3=clr
    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_LAP   = 2;
    localparam int B_CLR   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_e;

    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d;
    logic [3:0]    deb_dly_q;
    logic [3:0]    evt_q, evt_d;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          freeze_q, freeze_d;
    logic          running_q, running_d;
    logic          ovf_q, ovf_d;

    logic is_run, is_rest;
    logic do_clr, do_stop, do_start, do_lap;

    assign btn_raw = {clr_btn, lap_btn, stop_btn, start_btn};

    // Debounce: the synced value must disagree with the debounced value for
    // DEB_CYCLES consecutive cycles; any return to agreement restarts the count.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = deb_cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
        // Rising edge of the debounced level; registered so the FSM sees a
        // clean one-cycle pulse.
        evt_d = deb_q & ~deb_dly_q;
    end

    // Only events meaningful in the current state qualify; priority is then
    // clr > stop > start > lap among the qualified ones.
    assign is_run   = (state_q == RUN) || (state_q == LAP);
    assign is_rest  = (state_q == IDLE) || (state_q == PAUSE);
    assign do_clr   = evt_q[B_CLR] && is_rest;
    assign do_stop  = evt_q[B_STOP] && is_run;
    assign do_start = evt_q[B_START] && is_rest && !ovf_q;
    assign do_lap   = evt_q[B_LAP] && is_run;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        ovf_d     = ovf_q;

        if (do_clr) begin
            state_d   = IDLE;
            cnt_clr_d = 1'b1;
            ovf_d     = 1'b0;
            pre_d     = '0;
        end else if (do_stop) begin
            // A stop on the tick edge suppresses the tick and keeps pre.
            state_d = PAUSE;
            if (pre_q != PRE_MAX) begin
                pre_d = pre_q + 1'b1;
            end
        end else begin
            if (do_start) begin
                state_d = RUN;
            end else if (do_lap) begin
                state_d = (state_q == LAP) ? RUN : LAP;
            end
            if (is_run) begin
                if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    if (cnt_max) begin
                        // Saturated: halt instead of wrapping past 59:59.
                        state_d = PAUSE;
                        ovf_d   = 1'b1;
                    end else begin
                        cnt_en_d = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        end

        if (state_q == IDLE) begin
            pre_d = '0;
        end

        freeze_d  = (state_d == LAP);
        running_d = (state_d == RUN) || (state_d == LAP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            evt_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            state_q   <= IDLE;
            pre_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            freeze_q  <= 1'b0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            evt_q     <= evt_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            freeze_q  <= freeze_d;
            running_q <= running_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cnt_en      = cnt_en_q;
    assign cnt_clr     = cnt_clr_q;
    assign disp_freeze = freeze_q;
    assign running     = running_q;
    assign state       = state_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TICK_DIV=8, DEB_CYCLES=3.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btns;      // 0=start 1=stop 2=lap 3=clr
    logic       cnt_max;
    logic       cnt_en, cnt_clr, disp_freeze, running, ovf;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] M_START = 4'b0001;
    localparam logic [3:0] M_STOP  = 4'b0010;
    localparam logic [3:0] M_LAP   = 4'b0100;
    localparam logic [3:0] M_CLR   = 4'b1000;

    stopwatch_ctrl #(.TICK_DIV(8), .DEB_CYCLES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_btn  (btns[0]),
        .stop_btn   (btns[1]),
        .lap_btn    (btns[2]),
        .clr_btn    (btns[3]),
        .cnt_max    (cnt_max),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .disp_freeze(disp_freeze),
        .running    (running),
        .state      (state),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold buttons for 4 edges then wait until just after the edge where the
    // FSM acts (edge 6 counted from the first edge with the button high).
    task automatic act(input logic [3:0] m);
        btns = btns | m;
        step(4);
        btns = btns & ~m;
        step(3);
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cnt_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; btns = 4'b0; cnt_max = 1'b0;
        step(3);
        checks++; if ({cnt_en, cnt_clr, disp_freeze, running, ovf} !== 5'b0) begin errors++; $display("FAIL reset_flags: got=%b exp=00000", {cnt_en, cnt_clr, disp_freeze, running, ovf}); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got=%b exp=00", state); end
        rst_n = 1'b1;
        step(1);
        checks++; if (state !== 2'b00 || running !== 1'b0) begin errors++; $display("FAIL post_reset_idle: state=%b running=%b exp 00/0", state, running); end
    endtask

    task automatic test_start;
        logic [1:0] exp_st;
        logic       exp_en;
        btns[0] = 1'b1;
        for (int k = 0; k <= 31; k++) begin
            step(1);
            if (k == 9) btns[0] = 1'b0;
            exp_st = (k >= 6) ? 2'b01 : 2'b00;
            exp_en = (k == 14) || (k == 22) || (k == 30);
            checks++; if (state !== exp_st) begin errors++; $display("FAIL start_state edge %0d: got=%b exp=%b", k, state, exp_st); end
            checks++; if (cnt_en !== exp_en) begin errors++; $display("FAIL start_cnt_en edge %0d: got=%b exp=%b", k, cnt_en, exp_en); end
        end
    endtask

    task automatic test_stop_resume;
        bit ok;
        bit bad;
        wait_en(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sr_sync_tick: got=no cnt_en exp=cnt_en within 20"); end
        step(7);
        act(M_STOP);
        checks++; if (state !== 2'b10 || cnt_en !== 1'b0) begin errors++; $display("FAIL sr_pause: state=%b cnt_en=%b exp 10/0", state, cnt_en); end
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (cnt_en !== 1'b0 || state !== 2'b10) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL sr_hold: got=activity in pause exp=none"); end
        act(M_START);
        checks++; if (state !== 2'b01 || cnt_en !== 1'b0) begin errors++; $display("FAIL sr_resume: state=%b cnt_en=%b exp 01/0", state, cnt_en); end
        step(1);
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL sr_en_plus1: got=%b exp=0", cnt_en); end
        step(1);
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL sr_en_plus2: got=%b exp=1", cnt_en); end
        step(1);
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL sr_en_plus3: got=%b exp=0", cnt_en); end
    endtask

    task automatic test_lap;
        bit ok;
        act(M_LAP);
        checks++; if (state !== 2'b11 || disp_freeze !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL lap_enter: state=%b frz=%b run=%b exp 11/1/1", state, disp_freeze, running); end
        wait_en(ok);
        checks++; if (!ok || disp_freeze !== 1'b1 || state !== 2'b11) begin errors++; $display("FAIL lap_counting: en_seen=%0d frz=%b state=%b exp 1/1/11", ok, disp_freeze, state); end
        step(8);
        act(M_LAP);
        checks++; if (state !== 2'b01 || disp_freeze !== 1'b0) begin errors++; $display("FAIL lap_exit: state=%b frz=%b exp 01/0", state, disp_freeze); end
        step(8);
        act(M_LAP);
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL lap_reenter: state=%b exp=11", state); end
        act(M_STOP);
        checks++; if (state !== 2'b10 || disp_freeze !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL lap_stop: state=%b frz=%b run=%b exp 10/0/0", state, disp_freeze, running); end
    endtask

    task automatic test_priority;
        act(M_START);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL pri_run: state=%b exp=01", state); end
        step(8);
        act(M_STOP | M_CLR);
        checks++; if (state !== 2'b10 || cnt_clr !== 1'b0) begin errors++; $display("FAIL pri_stop_clr: state=%b clr=%b exp 10/0", state, cnt_clr); end
        step(1);
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL pri_no_clr: got=%b exp=0", cnt_clr); end
        step(8);
        act(M_CLR);
        checks++; if (state !== 2'b00 || cnt_clr !== 1'b1) begin errors++; $display("FAIL clr_pause: state=%b clr=%b exp 00/1", state, cnt_clr); end
        step(1);
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_one_cycle: got=%b exp=0", cnt_clr); end
        step(8);
        act(M_START);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            checks++; if (cnt_en !== (k == 8)) begin errors++; $display("FAIL clr_pre_zero +%0d: got=%b exp=%b", k, cnt_en, (k == 8)); end
        end
        step(8);
        act(M_CLR);
        checks++; if (state !== 2'b01 || cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_in_run: state=%b clr=%b exp 01/0", state, cnt_clr); end
    endtask

    task automatic test_saturate;
        bit found;
        bit en_seen;
        cnt_max = 1'b1;
        found = 1'b0; en_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cnt_en !== 1'b0) en_seen = 1'b1;
            if (state === 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found || en_seen) begin errors++; $display("FAIL sat_stop: paused=%0d en_seen=%0d exp 1/0", found, en_seen); end
        checks++; if (ovf !== 1'b1 || running !== 1'b0 || disp_freeze !== 1'b0) begin errors++; $display("FAIL sat_flags: ovf=%b run=%b frz=%b exp 1/0/0", ovf, running, disp_freeze); end
        step(8);
        act(M_START);
        checks++; if (state !== 2'b10 || ovf !== 1'b1) begin errors++; $display("FAIL sat_start_ignored: state=%b ovf=%b exp 10/1", state, ovf); end
        step(8);
        act(M_CLR);
        checks++; if (state !== 2'b00 || ovf !== 1'b0 || cnt_clr !== 1'b1) begin errors++; $display("FAIL sat_clr: state=%b ovf=%b clr=%b exp 00/0/1", state, ovf, cnt_clr); end
        cnt_max = 1'b0;
    endtask

    task automatic test_glitch;
        bit moved;
        logic [1:0] exp_st;
        step(8);
        btns[0] = 1'b1; step(2);
        btns[0] = 1'b0; step(1);
        btns[0] = 1'b1; step(2);
        btns[0] = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (state !== 2'b00) moved = 1'b1;
        end
        checks++; if (moved) begin errors++; $display("FAIL glitch_ignored: got=state change exp=stay 00"); end
        btns[0] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step(1);
            if (k == 5) btns[0] = 1'b0;
            exp_st = (k >= 6) ? 2'b01 : 2'b00;
            checks++; if (state !== exp_st) begin errors++; $display("FAIL glitch_hold edge %0d: got=%b exp=%b", k, state, exp_st); end
        end
    endtask

    task automatic test_reset_mid_debounce;
        btns[2] = 1'b1;
        step(3);
        rst_n = 1'b0;
        step(1);
        checks++; if ({cnt_en, cnt_clr, disp_freeze, running, ovf} !== 5'b0 || state !== 2'b00) begin errors++; $display("FAIL reset_mid: flags=%b state=%b exp 00000/00", {cnt_en, cnt_clr, disp_freeze, running, ovf}, state); end
        btns[2] = 1'b0;
        rst_n = 1'b1;
        step(10);
        checks++; if (state !== 2'b00 || disp_freeze !== 1'b0) begin errors++; $display("FAIL reset_mid_after: state=%b frz=%b exp 00/0", state, disp_freeze); end
    endtask

    initial begin
        test_reset;
        test_start;
        test_stop_resume;
        test_lap;
        test_priority;
        test_saturate;
        test_glitch;
        test_reset_mid_debounce;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
